range_monitor: RTL and testbench
================================

RANGE_MONITOR -- requirements
Module: range_monitor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning sample width in bits.
REQ-002 The block SHALL have parameter CHANNELS, default 4, meaning number of independent channels (>=1).
REQ-003 The block SHALL have parameter CNT_W, default 8, meaning per-channel violation counter width.
REQ-004 The block SHALL have parameters LO and HI, defaults -10 and 10, meaning the closed legal range [LO:HI], signed.
REQ-005 The block SHALL have parameters EX_LO and EX_HI, defaults 1 and 2, meaning the half-open excluded sub-range [EX_LO:EX_HI).
REQ-006 The block SHALL have parameter DEFAULT, default 0, meaning the reset value of each channel's last-good register.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-008 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-009 The block SHALL have port in_valid, input, 1 bit: sample strobe.
REQ-010 The block SHALL have port in_ch, input, CH_W=max(1,clog2(CHANNELS)) bits: channel index.
REQ-011 The block SHALL have port in_data, input, WIDTH bits: signed sample.
REQ-012 The block SHALL have port clear, input, 1 bit: synchronous clear of counters and sticky flags.
REQ-013 The block SHALL have ports out_valid (1 bit), out_ch (CH_W bits), out_data (WIDTH bits) and out_flag (2 bits), all outputs, carrying the processed sample.
REQ-014 The block SHALL have port viol_cnt, output, CHANNELS*CNT_W bits, with channel n at bits [n*CNT_W +: CNT_W].
REQ-015 The block SHALL have port sticky, output, CHANNELS bits: per-channel "any violation since clear".

Function
REQ-016 Legality checks at elaboration SHALL be: LO<=HI; LO<=DEFAULT<=HI; DEFAULT outside [EX_LO:EX_HI); EX_LO<=EX_HI; any failure SHALL be a fatal elaboration error.
REQ-017 Stage 1 SHALL register in_valid/in_ch/in_data and the classification: 0=OK, 1=BELOW (<LO), 2=ABOVE (>HI), 3=EXCLUDED (EX_LO<=x<EX_HI, checked only inside [LO:HI]).
REQ-018 Bounds SHALL be inclusive at LO and HI, inclusive at EX_LO and exclusive at EX_HI; EX_LO==EX_HI SHALL exclude nothing.
REQ-019 Stage 2 SHALL drive the outputs, giving a fixed latency of 2 cycles from in_valid to out_valid, with no stall and one sample accepted per cycle.
REQ-020 out_data SHALL be in_data for OK, LO for BELOW, HI for ABOVE, and the channel's last-good value for EXCLUDED.
REQ-021 The channel's last-good register SHALL update to out_data on every OK, BELOW or ABOVE sample, and SHALL NOT update on EXCLUDED.
REQ-022 A non-OK sample SHALL increment viol_cnt[ch] and set sticky[ch] in stage 2; the counter SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-023 clear SHALL zero all counters and sticky bits on the next edge; when clear and a stage-2 violation coincide, clear SHALL win and that violation SHALL NOT be counted.
REQ-024 Back-to-back samples on the same channel SHALL see the last-good value written by the immediately preceding sample (forwarding, no hazard).
REQ-025 in_ch>=CHANNELS SHALL be dropped at stage 1: out_valid stays 0 and no state changes.
REQ-026 With out_valid=0, out_ch/out_data/out_flag SHALL hold their previous values.

Reset
REQ-027 rst SHALL asynchronously clear both pipeline valids, out_ch, out_data, out_flag, viol_cnt and sticky to 0, and set every last-good register to DEFAULT.
REQ-028 Samples in flight at reset assertion SHALL be discarded; the first valid output after rst deasserts SHALL appear 2 cycles after the first accepted in_valid.

Structure
REQ-029 The flag encoding (OK/BELOW/ABOVE/EXCLUDED) and the CH_W derivation SHALL live in a shared package range_pkg.
REQ-030 Classification SHALL be a single combinational sub-module range_classify (parameters WIDTH, LO, HI, EX_LO, EX_HI), instantiated once in stage 1.

Verification
REQ-031 Defaults: samples ch0 = -10, 10, 0 -> out_data -10, 10, 0 with flag 0 each, exactly 2 cycles after each input; viol_cnt[0]=0.
REQ-032 ch1 = -11, 11 -> out_data -10 (flag 1), 10 (flag 2); viol_cnt[1]=2 and sticky[1]=1.
REQ-033 ch2 = 5, then 1 -> second output is 5 (flag 3); ch2 = 2 -> output 2 (flag 0); ch3 = 1 right after reset -> output 0.
REQ-034 CNT_W=2 with 5 violations on ch0 -> viol_cnt[0]=3; clear asserted in the same cycle as a stage-2 violation -> count 0 and sticky 0.
REQ-035 Assert rst while 2 samples are in flight -> no out_valid pulse, all counters 0, last-good = DEFAULT.
REQ-036 Elaborating with DEFAULT=1 (inside the exclusion) -> fatal elaboration error; with in_ch=4 and CHANNELS=4 -> no output and no state change.

Source files
------------

// File: rtl/range_pkg.sv
// Shared flag encoding and channel-index width helper for the range monitor.
package range_pkg;

    typedef enum logic [1:0] {
        FlagOk    = 2'd0,
        FlagBelow = 2'd1,
        FlagAbove = 2'd2,
        FlagExcl  = 2'd3
    } flag_e;

    function automatic int ch_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/range_classify.sv
// Combinational classifier: legal range, below/above, or inside the excluded hole.
module range_classify
    import range_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LO    = -10,
    parameter int HI    = 10,
    parameter int EX_LO = 1,
    parameter int EX_HI = 2
) (
    input  logic signed [WIDTH-1:0] data,
    output flag_e                   flag
);

    int val;
    assign val = int'(data);

    // Exclusion only applies inside the legal range; EX_LO == EX_HI is empty.
    always_comb begin
        flag = FlagOk;
        if (val < LO) begin
            flag = FlagBelow;
        end else if (val > HI) begin
            flag = FlagAbove;
        end else if (val >= EX_LO && val < EX_HI) begin
            flag = FlagExcl;
        end
    end

endmodule

// File: rtl/range_monitor.sv
// Two-stage per-channel range monitor: classify, clamp/substitute, count violations.
module range_monitor
    import range_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8,
    parameter int LO       = -10,
    parameter int HI       = 10,
    parameter int EX_LO    = 1,
    parameter int EX_HI    = 2,
    parameter int DEFAULT  = 0,
    localparam int CH_W    = ch_width(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [CH_W-1:0]           in_ch,
    input  logic signed [WIDTH-1:0]   in_data,
    input  logic                      clear,
    output logic                      out_valid,
    output logic [CH_W-1:0]           out_ch,
    output logic signed [WIDTH-1:0]   out_data,
    output logic [1:0]                out_flag,
    output logic [CHANNELS*CNT_W-1:0] viol_cnt,
    output logic [CHANNELS-1:0]       sticky
);

    if (LO > HI || DEFAULT < LO || DEFAULT > HI || EX_LO > EX_HI ||
        (DEFAULT >= EX_LO && DEFAULT < EX_HI)) begin : g_bad_params
        $fatal(1, "range_monitor: illegal LO/HI/EX_LO/EX_HI/DEFAULT combination");
    end

    localparam logic signed [WIDTH-1:0] LoW  = WIDTH'(LO);
    localparam logic signed [WIDTH-1:0] HiW  = WIDTH'(HI);
    localparam logic signed [WIDTH-1:0] DefW = WIDTH'(DEFAULT);

    // Stage 1
    flag_e                   cls_flag;
    logic                    ch_ok;
    logic                    accept;
    logic                    s1_valid;
    logic [CH_W-1:0]         s1_ch;
    logic signed [WIDTH-1:0] s1_data;
    flag_e                   s1_flag;

    range_classify #(
        .WIDTH (WIDTH),
        .LO    (LO),
        .HI    (HI),
        .EX_LO (EX_LO),
        .EX_HI (EX_HI)
    ) u_classify (
        .data (in_data),
        .flag (cls_flag)
    );

    assign ch_ok  = 32'(in_ch) < CHANNELS;
    assign accept = in_valid && ch_ok;

    // Payload only loads on accepted samples, so s1_ch is always a legal index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_ch    <= '0;
            s1_data  <= '0;
            s1_flag  <= FlagOk;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_ch   <= in_ch;
                s1_data <= in_data;
                s1_flag <= cls_flag;
            end
        end
    end

    // Stage 2
    logic signed [WIDTH-1:0] lg_q  [CHANNELS];
    logic [CNT_W-1:0]        cnt_q [CHANNELS];
    logic signed [WIDTH-1:0] s2_data;

    // lg_q is written at the same edge that emits a sample, so the next
    // sample on that channel already sees it: no forwarding path needed.
    always_comb begin
        s2_data = s1_data;
        case (s1_flag)
            FlagBelow: s2_data = LoW;
            FlagAbove: s2_data = HiW;
            FlagExcl:  s2_data = lg_q[s1_ch];
            default:   s2_data = s1_data;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            out_flag  <= '0;
            sticky    <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                lg_q[i]  <= DefW;
                cnt_q[i] <= '0;
            end
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_ch   <= s1_ch;
                out_data <= s2_data;
                out_flag <= s1_flag;
                if (s1_flag != FlagExcl) begin
                    lg_q[s1_ch] <= s2_data;
                end
            end
            if (clear) begin
                sticky <= '0;
                for (int i = 0; i < CHANNELS; i++) begin
                    cnt_q[i] <= '0;
                end
            end else if (s1_valid && s1_flag != FlagOk) begin
                sticky[s1_ch] <= 1'b1;
                if (cnt_q[s1_ch] != {CNT_W{1'b1}}) begin
                    cnt_q[s1_ch] <= cnt_q[s1_ch] + 1'b1;
                end
            end
        end
    end

    for (genvar n = 0; n < CHANNELS; n++) begin : g_pack
        assign viol_cnt[n*CNT_W +: CNT_W] = cnt_q[n];
    end

endmodule

// File: tb/tb_range_monitor.sv
// Directed bench: default instance plus a CHANNELS=3 / CNT_W=2 instance on shared stimulus.
module tb_range_monitor;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic [1:0]         in_ch;
    logic signed [15:0] in_data;
    logic               clear;

    logic               o_valid;
    logic [1:0]         o_ch;
    logic signed [15:0] o_data;
    logic [1:0]         o_flag;
    logic [31:0]        o_cnt;
    logic [3:0]         o_sticky;

    logic               o2_valid;
    logic [1:0]         o2_ch;
    logic signed [15:0] o2_data;
    logic [1:0]         o2_flag;
    logic [5:0]         o2_cnt;
    logic [2:0]         o2_sticky;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses;

    always #5 clk = ~clk;

    range_monitor dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ch    (in_ch),
        .in_data  (in_data),
        .clear    (clear),
        .out_valid(o_valid),
        .out_ch   (o_ch),
        .out_data (o_data),
        .out_flag (o_flag),
        .viol_cnt (o_cnt),
        .sticky   (o_sticky)
    );

    range_monitor #(
        .CHANNELS (3),
        .CNT_W    (2)
    ) dut2 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ch    (in_ch),
        .in_data  (in_data),
        .clear    (clear),
        .out_valid(o2_valid),
        .out_ch   (o2_ch),
        .out_data (o2_data),
        .out_flag (o2_flag),
        .viol_cnt (o2_cnt),
        .sticky   (o2_sticky)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check default-instance output bus; data compared sign-extended.
    task automatic chk_o(input string tag, input logic v, input logic [1:0] ch,
                         input int d, input logic [1:0] f);
        chk({tag, ".valid"}, 32'(o_valid), 32'(v));
        chk({tag, ".ch"}, 32'(o_ch), 32'(ch));
        chk({tag, ".data"}, int'(o_data), d);
        chk({tag, ".flag"}, 32'(o_flag), 32'(f));
    endtask

    // Drive one cycle of inputs; returns at the following negedge.
    task automatic cyc(input logic v, input logic [1:0] ch, input int d, input logic clr);
        in_valid = v;
        in_ch    = ch;
        in_data  = 16'(d);
        clear    = clr;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_ch = '0; in_data = '0; clear = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_o("reset", 1'b0, 2'd0, 0, 2'd0);
        chk("reset.cnt", o_cnt, 32'h0);
        chk("reset.sticky", 32'(o_sticky), 32'h0);
        chk("reset.cnt2", 32'(o2_cnt), 32'h0);
        rst = 1'b0;

        // ch3 = 1 straight after reset: excluded, substitutes DEFAULT
        cyc(1'b1, 2'd3, 1, 1'b0);
        chk("lat.notyet", 32'(o_valid), 32'h0);
        cyc(1'b1, 2'd0, -10, 1'b0);
        chk_o("ch3.excl", 1'b1, 2'd3, 0, 2'd3);
        chk("dut2.drop", 32'(o2_valid), 32'h0);
        cyc(1'b1, 2'd0, 10, 1'b0);
        chk_o("ch0.lo", 1'b1, 2'd0, -10, 2'd0);
        chk("dut2.ch0", int'(o2_data), -10);
        cyc(1'b1, 2'd0, 0, 1'b0);
        chk_o("ch0.hi", 1'b1, 2'd0, 10, 2'd0);
        cyc(1'b0, 2'd0, 0, 1'b0);
        chk_o("ch0.zero", 1'b1, 2'd0, 0, 2'd0);
        chk("ch0.cnt", 32'(o_cnt[7:0]), 32'h0);

        // ch1 below / above: clamped
        cyc(1'b1, 2'd1, -11, 1'b0);
        cyc(1'b1, 2'd1, 11, 1'b0);
        chk_o("ch1.below", 1'b1, 2'd1, -10, 2'd1);
        cyc(1'b0, 2'd0, 0, 1'b0);
        chk_o("ch1.above", 1'b1, 2'd1, 10, 2'd2);
        chk("ch1.cnt", 32'(o_cnt[15:8]), 32'h2);
        chk("ch1.sticky", 32'(o_sticky[1]), 32'h1);
        cyc(1'b0, 2'd0, 0, 1'b0);
        chk_o("hold", 1'b0, 2'd1, 10, 2'd2);

        // ch2: last-good substitution and back-to-back forwarding
        cyc(1'b1, 2'd2, 5, 1'b0);
        cyc(1'b1, 2'd2, 1, 1'b0);
        chk_o("ch2.five", 1'b1, 2'd2, 5, 2'd0);
        cyc(1'b1, 2'd2, 2, 1'b0);
        chk_o("ch2.excl", 1'b1, 2'd2, 5, 2'd3);
        cyc(1'b1, 2'd2, -20, 1'b0);
        chk_o("ch2.exhi", 1'b1, 2'd2, 2, 2'd0);
        cyc(1'b1, 2'd2, 1, 1'b0);
        chk_o("ch2.below", 1'b1, 2'd2, -10, 2'd1);
        cyc(1'b0, 2'd0, 0, 1'b0);
        chk_o("ch2.fwd", 1'b1, 2'd2, -10, 2'd3);
        chk("cnt.all", o_cnt, 32'h0103_0200);
        chk("sticky.all", 32'(o_sticky), 32'hE);
        chk("dut2.cnt", 32'(o2_cnt), 32'h38);
        chk("dut2.sticky", 32'(o2_sticky), 32'h6);

        // Saturation: 5 violations on ch0
        for (int i = 0; i < 5; i++) cyc(1'b1, 2'd0, 100, 1'b0);
        cyc(1'b0, 2'd0, 0, 1'b0);
        chk_o("sat.out", 1'b1, 2'd0, 10, 2'd2);
        chk("sat.cnt", o_cnt, 32'h0103_0205);
        chk("sat.cnt2", 32'(o2_cnt), 32'h3B);
        chk("sat.sticky2", 32'(o2_sticky), 32'h7);

        // clear coinciding with a stage-2 violation wins
        cyc(1'b1, 2'd1, 50, 1'b0);
        cyc(1'b0, 2'd0, 0, 1'b1);
        chk_o("clr.out", 1'b1, 2'd1, 10, 2'd2);
        chk("clr.cnt", o_cnt, 32'h0);
        chk("clr.sticky", 32'(o_sticky), 32'h0);
        chk("clr.cnt2", 32'(o2_cnt), 32'h0);
        cyc(1'b1, 2'd0, -50, 1'b0);
        cyc(1'b0, 2'd0, 0, 1'b0);
        chk_o("postclr", 1'b1, 2'd0, -10, 2'd1);
        chk("postclr.cnt", o_cnt, 32'h1);
        chk("postclr.sticky", 32'(o_sticky), 32'h1);

        // Reset with two samples in flight
        cyc(1'b1, 2'd2, 7, 1'b0);
        in_valid = 1'b1; in_ch = 2'd2; in_data = 16'sd8;
        #2 rst = 1'b1;
        #1;
        chk_o("arst", 1'b0, 2'd0, 0, 2'd0);
        chk("arst.cnt", o_cnt, 32'h0);
        chk("arst.sticky", 32'(o_sticky), 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 2'd0, 0, 1'b0);
            if (o_valid) pulses++;
        end
        chk("arst.pulses", 32'(pulses), 32'h0);
        cyc(1'b1, 2'd2, 1, 1'b0);
        chk("arst.lat", 32'(o_valid), 32'h0);
        cyc(1'b0, 2'd0, 0, 1'b0);
        chk_o("arst.default", 1'b1, 2'd2, 0, 2'd3);
        chk("arst.cnt2", o_cnt, 32'h0001_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
